addr_cal_unit: RTL and testbench

ADDR_CAL_UNIT -- requirements
Module: addr_cal

---
 rtl/addr_cal_pkg.sv | 60 ++++++
 rtl/addr_cal_if.sv | 22 ++
 rtl/addr_cal_axis.sv | 27 ++
 rtl/addr_cal_unit.sv | 74 +++++++
 tb/tb_addr_cal_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/addr_cal_pkg.sv
// Shared constants, field layouts and unpack helpers for the sprite address calculator.
package addr_cal_pkg;

    localparam int ADDR_W    = 16;
    localparam int COORD_W   = 10;
    localparam int REL_W     = 12;
    localparam int PATTERN_W = 80;
    localparam int SPRITE_W  = 32;

    localparam int PAT_FIELD_W    = 16;
    localparam int PAT_BASE_LSB   = 64;
    localparam int PAT_PAT_W_LSB  = 48;
    localparam int PAT_PAT_H_LSB  = 32;
    localparam int PAT_DISP_W_LSB = 16;
    localparam int PAT_DISP_H_LSB = 0;

    localparam int SPR_FIELD_W     = 10;
    localparam int SPR_VISIBLE_BIT = 31;
    localparam int SPR_FLIP_BIT    = 30;
    localparam int SPR_X_LSB       = 20;
    localparam int SPR_Y_LSB       = 10;
    localparam int SPR_SHIFT_LSB   = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] base_addr;
        logic [ADDR_W-1:0] pat_w;
        logic [ADDR_W-1:0] pat_h;
        logic [ADDR_W-1:0] disp_w;
        logic [ADDR_W-1:0] disp_h;
    } pattern_t;

    typedef struct packed {
        logic               visible;
        logic               flip;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] shift;
    } sprite_t;

    function automatic pattern_t unpack_pattern(input logic [PATTERN_W-1:0] raw);
        pattern_t p;
        p.base_addr = raw[PAT_BASE_LSB   +: PAT_FIELD_W];
        p.pat_w     = raw[PAT_PAT_W_LSB  +: PAT_FIELD_W];
        p.pat_h     = raw[PAT_PAT_H_LSB  +: PAT_FIELD_W];
        p.disp_w    = raw[PAT_DISP_W_LSB +: PAT_FIELD_W];
        p.disp_h    = raw[PAT_DISP_H_LSB +: PAT_FIELD_W];
        return p;
    endfunction

    function automatic sprite_t unpack_sprite(input logic [SPRITE_W-1:0] raw);
        sprite_t s;
        s.visible = raw[SPR_VISIBLE_BIT];
        s.flip    = raw[SPR_FLIP_BIT];
        s.x       = raw[SPR_X_LSB     +: SPR_FIELD_W];
        s.y       = raw[SPR_Y_LSB     +: SPR_FIELD_W];
        s.shift   = raw[SPR_SHIFT_LSB +: SPR_FIELD_W];
        return s;
    endfunction

endpackage

// File: rtl/addr_cal_if.sv
// Pixel/sprite bus: raster position and sprite descriptors in, pattern address out.
interface addr_cal_if;
    import addr_cal_pkg::*;

    logic [PATTERN_W-1:0] pattern_info;
    logic [SPRITE_W-1:0]  sprite_info;
    logic [COORD_W-1:0]   hcount;
    logic [COORD_W-1:0]   vcount;
    logic [ADDR_W-1:0]    addr_output;
    logic                 valid;

    modport master (
        output pattern_info, sprite_info, hcount, vcount,
        input  addr_output, valid
    );

    modport slave (
        input  pattern_info, sprite_info, hcount, vcount,
        output addr_output, valid
    );

endinterface

// File: rtl/addr_cal_axis.sv
// One raster axis: offset from the sprite origin, range check and tiled pattern index.
module addr_cal_axis
    import addr_cal_pkg::*;
(
    input  logic [COORD_W-1:0] origin,
    input  logic [COORD_W-1:0] shift,
    input  logic [COORD_W-1:0] count,
    input  logic [ADDR_W-1:0]  extent,
    input  logic [ADDR_W-1:0]  pat_size,
    output logic               hit,
    output logic [ADDR_W-1:0]  idx
);

    logic signed [REL_W-1:0] start;
    logic signed [REL_W-1:0] rel;
    logic        [ADDR_W-1:0] rel_ext;

    assign start   = $signed({{(REL_W-COORD_W){1'b0}}, origin})
                   - $signed({{(REL_W-COORD_W){1'b0}}, shift});
    assign rel     = $signed({{(REL_W-COORD_W){1'b0}}, count}) - start;
    assign rel_ext = {{(ADDR_W-REL_W){rel[REL_W-1]}}, rel};

    // Sign check first; a zero extent can never satisfy the unsigned compare.
    assign hit = !rel[REL_W-1] && (rel_ext < extent);
    assign idx = rel_ext & (pat_size - ADDR_W'(1));

endmodule

// File: rtl/addr_cal_unit.sv
// Registered pattern-memory address for the current pixel of a tiled sprite.
// Define ADDR_CAL_FLIP_EN to honour the horizontal mirror bit of sprite_info.
module addr_cal_unit
    import addr_cal_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    addr_cal_if.slave    bus
);

    pattern_t            pat;
    sprite_t             spr;
    logic                x_hit;
    logic                y_hit;
    logic                hit;
    logic                flip;
    logic [ADDR_W-1:0]   x_idx;
    logic [ADDR_W-1:0]   y_idx;
    logic [ADDR_W-1:0]   col;
    logic [ADDR_W-1:0]   next_addr;

    assign pat = unpack_pattern(bus.pattern_info);
    assign spr = unpack_sprite(bus.sprite_info);

    addr_cal_axis u_axis_x (
        .origin   (spr.x),
        .shift    (spr.shift),
        .count    (bus.hcount),
        .extent   (pat.disp_w),
        .pat_size (pat.pat_w),
        .hit      (x_hit),
        .idx      (x_idx)
    );

    addr_cal_axis u_axis_y (
        .origin   (spr.y),
        .shift    ('0),
        .count    (bus.vcount),
        .extent   (pat.disp_h),
        .pat_size (pat.pat_h),
        .hit      (y_hit),
        .idx      (y_idx)
    );

`ifdef ADDR_CAL_FLIP_EN
    assign flip = spr.flip;
`else
    // The mirror bit is deliberately ignored in this build.
    assign flip = spr.flip & 1'b0;
`endif

    // NOTE: col gets its default before the conditional override so no latch is inferred.
    always_comb begin
        col = x_idx;
        if (flip) begin
            col = pat.pat_w - ADDR_W'(1) - x_idx;
        end
    end

    assign next_addr = pat.base_addr + y_idx * pat.pat_w + col;
    assign hit       = spr.visible && x_hit && y_hit;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.addr_output <= '0;
            bus.valid       <= 1'b0;
        end else begin
            bus.valid       <= hit;
            bus.addr_output <= hit ? next_addr : '0;
        end
    end

endmodule

// File: tb/tb_addr_cal_unit.sv
// Scoreboard bench for addr_cal_unit: directed corner cases plus randomized sprites vs. an arithmetic model.
module tb_addr_cal_unit;

`ifdef ADDR_CAL_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [15:0] exp_addr_q[$];
    logic        exp_valid_q[$];
    string       name_q[$];

    addr_cal_if bus ();

    addr_cal_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] ea, input logic ev, input string name);
        exp_addr_q.push_back(ea);
        exp_valid_q.push_back(ev);
        name_q.push_back(name);
    endtask

    task automatic drive(input logic [79:0] pat, input logic [31:0] spr,
                         input logic [9:0] h, input logic [9:0] v,
                         input logic [15:0] ea, input logic ev, input string name);
        @(negedge clk);
        bus.pattern_info = pat;
        bus.sprite_info  = spr;
        bus.hcount       = h;
        bus.vcount       = v;
        push_exp(ea, ev, name);
    endtask

    // Reference: signed integer offsets, modulo tiling, optional mirror, 16-bit wrap.
    function automatic void model(input int base, input int pw, input int ph,
                                  input int dw, input int dh, input int vis,
                                  input int flp, input int x, input int y,
                                  input int sh, input int h, input int v,
                                  output logic [15:0] ea, output logic ev);
        int rx;
        int ry;
        int c;
        int r;
        rx = h - (x - sh);
        ry = v - y;
        ev = (vis != 0) && rx >= 0 && rx < dw && ry >= 0 && ry < dh;
        ea = '0;
        if (ev) begin
            c = rx % pw;
            r = ry % ph;
            if (FLIP_EN && flp != 0) c = pw - 1 - c;
            ea = 16'((base + r * pw + c) % 65536);
        end
    endfunction

    // Monitor: every post-edge sample while out of reset consumes one expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset && exp_addr_q.size() > 0) begin
                string nm;
                nm = name_q.pop_front();
                check({nm, ".valid"}, 32'(bus.valid), 32'(exp_valid_q.pop_front()));
                check({nm, ".addr"},  32'(bus.addr_output), 32'(exp_addr_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [79:0] PAT_BASIC = {16'd0, 16'd16, 16'd16, 16'd16, 16'd16};
    localparam logic [31:0] SPR_BASIC = {1'b1, 1'b0, 10'd100, 10'd50, 10'd0};
    localparam logic [31:0] SPR_FLIP  = {1'b1, 1'b1, 10'd100, 10'd50, 10'd0};
    localparam logic [15:0] FLIP_ADDR = FLIP_EN ? 16'd58 : 16'd53;

    initial begin
        int base, pw, ph, dw, dh, vis, flp, x, y, sh, h, v;
        logic [15:0] ea;
        logic        ev;

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.pattern_info = '0;
        bus.sprite_info  = '0;
        bus.hcount       = '0;
        bus.vcount       = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 32'(bus.valid), 32'd0);
        check("reset.addr",  32'(bus.addr_output), 32'd0);

        // Release with a hit already present: the first edge must produce it.
        @(negedge clk);
        bus.pattern_info = PAT_BASIC;
        bus.sprite_info  = SPR_BASIC;
        bus.hcount       = 10'd105;
        bus.vcount       = 10'd53;
        reset            = 1'b1;
        push_exp(16'd53, 1'b1, "first_after_reset");

        drive(PAT_BASIC, SPR_BASIC, 10'd105, 10'd53, 16'd53, 1'b1, "basic");
        drive(PAT_BASIC, SPR_FLIP,  10'd105, 10'd53, FLIP_ADDR, 1'b1, "flip");
        drive({16'd1280, 16'd16, 16'd16, 16'd32, 16'd16}, SPR_BASIC, 10'd120, 10'd50,
              16'd1284, 1'b1, "tiled_hit");
        drive({16'd1280, 16'd16, 16'd16, 16'd32, 16'd16}, SPR_BASIC, 10'd132, 10'd50,
              16'd0, 1'b0, "tiled_edge_miss");
        drive({16'd256, 16'd16, 16'd16, 16'd16, 16'd16}, {1'b1, 1'b0, 10'd100, 10'd50, 10'd30},
              10'd70, 10'd50, 16'd256, 1'b1, "shift_left_edge");
        drive({16'd256, 16'd16, 16'd16, 16'd16, 16'd16}, {1'b1, 1'b0, 10'd100, 10'd50, 10'd30},
              10'd69, 10'd50, 16'd0, 1'b0, "shift_neg_miss");
        drive(PAT_BASIC, {1'b0, 1'b0, 10'd100, 10'd50, 10'd0}, 10'd105, 10'd53,
              16'd0, 1'b0, "invisible");
        drive({16'd0, 16'd16, 16'd16, 16'd0, 16'd16}, SPR_BASIC, 10'd100, 10'd50,
              16'd0, 1'b0, "disp_w_zero");
        drive({16'd0, 16'd16, 16'd16, 16'd16, 16'd0}, SPR_BASIC, 10'd100, 10'd50,
              16'd0, 1'b0, "disp_h_zero");
        drive({16'hFFFF, 16'd16, 16'd16, 16'd16, 16'd16}, SPR_BASIC, 10'd105, 10'd53,
              16'd52, 1'b1, "base_wrap");
        drive({16'd0, 16'd16, 16'd16, 16'd16, 16'd16}, SPR_BASIC, 10'd105, 10'd66,
              16'd0, 1'b0, "bottom_edge_miss");

        // Asynchronous reset while a hit is being presented.
        drive(PAT_BASIC, SPR_BASIC, 10'd105, 10'd53, 16'd53, 1'b1, "pre_reset");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset.valid", 32'(bus.valid), 32'd0);
        check("async_reset.addr",  32'(bus.addr_output), 32'd0);
        @(posedge clk);
        #1;
        check("held_reset.valid", 32'(bus.valid), 32'd0);
        check("held_reset.addr",  32'(bus.addr_output), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        push_exp(16'd53, 1'b1, "reset_release");

        for (int i = 0; i < 300; i++) begin
            base = int'($urandom_range(0, 65535));
            pw   = 1 << $urandom_range(0, 8);
            ph   = 1 << $urandom_range(0, 8);
            case ($urandom_range(0, 9))
                0:       dw = 0;
                1:       dw = 65535;
                default: dw = int'($urandom_range(1, 300));
            endcase
            case ($urandom_range(0, 9))
                0:       dh = 0;
                1:       dh = 65535;
                default: dh = int'($urandom_range(1, 300));
            endcase
            vis = ($urandom_range(0, 7) != 0) ? 1 : 0;
            flp = int'($urandom_range(0, 1));
            x   = int'($urandom_range(0, 1023));
            y   = int'($urandom_range(0, 1023));
            sh  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 1023)) : 0;
            h   = (x - sh + int'($urandom_range(0, (dw > 300 ? 300 : dw) + 8)) - 4) & 1023;
            v   = (y + int'($urandom_range(0, (dh > 300 ? 300 : dh) + 8)) - 4) & 1023;
            model(base, pw, ph, dw, dh, vis, flp, x, y, sh, h, v, ea, ev);
            drive({16'(base), 16'(pw), 16'(ph), 16'(dw), 16'(dh)},
                  {1'(vis), 1'(flp), 10'(x), 10'(y), 10'(sh)},
                  10'(h), 10'(v), ea, ev, $sformatf("rnd%0d", i));
        end

        @(posedge clk);
        #3;
        check("scoreboard_drain", 32'(exp_addr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
